ntt_out_unpacker: RTL
=====================

# ntt_out_unpacker

Downstream stage of the NTT1024 core. It captures the even/odd-interleaved coefficient stream the core emits on `dout0` after `done` and applies the final conditional reduction into [0, q). It stores the coefficients in a local buffer at their natural-order index, then replays the polynomial in natural order 0..N-1 over a valid/ready stream to the host or the next arithmetic stage.

## Interface
- `DATA_W`, 32, coefficient word width.
- `RING_DEPTH_MAX`, 10, log2 of the largest ring; buffer depth is 2^RING_DEPTH_MAX.
- `RING_DEPTH_MIN`, 8, log2 of the smallest supported ring.

Ports:
- `clk  in  1`  single clock; all logic is on its rising edge.
- `reset  in  1`  asynchronous, active-low reset.
- `start  in  1`  one-cycle pulse; samples `ring_depth` and `q` and arms capture.
- `ring_depth  in  4`  log2 N, legal range 8..10.
- `q  in  DATA_W`  modulus taken from the core's parameter register (e.g. 8004097).
- `din_valid  in  1`  a coefficient is present on `din` this cycle.
- `din  in  DATA_W`  coefficient from the core's `dout0`.
- `dout_valid  out  1`  output word valid.
- `dout_ready  in  1`  consumer accepts the word.
- `dout  out  DATA_W`  natural-order coefficient.
- `dout_last  out  1`  asserted with coefficient N-1.
- `busy  out  1`  high in CAPTURE or DRAIN.
- `done  out  1`  one-cycle pulse after the last handshake.
- `err_ovf  out  1`  sticky flag: input arrived outside CAPTURE.
- `err_cfg  out  1`  sticky flag: illegal `ring_depth` at `start`.

## Operation
- FSM states are IDLE, CAPTURE and DRAIN.
- IDLE → CAPTURE on `start` with a legal `ring_depth`. The block latches N = 1<<ring_depth and latches `q`, clears the word counter m, and clears both error flags.
- `start` with `ring_depth` outside 8..10: set `err_cfg` and stay in IDLE.
- CAPTURE: each `din_valid` word m (0..N-1) is reduced (x ≥ q → x−q, else x) and written to buffer address (m>>1) + (m[0] ? N/2 : 0). m increments by 1.
  - When word N-1 is written, the FSM moves to DRAIN. Gaps in `din_valid` are allowed.
- DRAIN: read addresses 0..N-1 in order and present them on `dout`. The read pointer advances only on a handshake (`dout_valid & dout_ready`). `dout_last` is asserted with address N-1.
  - After the last handshake: pulse `done` and return to IDLE.
- `din_valid` in IDLE or DRAIN: the word is dropped, `err_ovf` is set, and the state is unaffected.
- `start` in CAPTURE or DRAIN aborts the current frame. The block re-samples its configuration, restarts CAPTURE, and deasserts `dout_valid` on the next cycle.
- `start` coincident with `din_valid`: the `start` is processed and the word is dropped, with no `err_ovf`.
- The reduction assumes din < 2q; any larger input is passed through after a single subtraction.

## Timing
- Reset values: `dout_valid`, `dout_last`, `busy`, `done`, `err_ovf` and `err_cfg` are 0; `dout` is 0; the FSM is in IDLE.
- Capture throughput is 1 word/cycle. Reduction is registered, so the RAM write lands 1 cycle after `din_valid`.
- The transition to DRAIN occurs the cycle after the final write.
- The first `dout_valid` is 2 cycles after entering DRAIN (1 cycle RAM read + output register).
- When `dout_ready` is held high, one word per cycle with no bubbles. A 2-entry skid buffer absorbs the read latency.
- When `dout_valid & !dout_ready`: `dout` and `dout_last` must be held stable.
- `done` is asserted the cycle after the N-th handshake. `busy` falls in the same cycle.

## Configuration
- `OUT_REDUCE_EN` defined: the conditional subtraction described above is compiled in.
- Not defined: `din` is stored unmodified and the `q` input is ignored. Latency is unchanged, because the register stage is kept.

## Structure
- Shared defines file holds:
  - the FSM state encodings;
  - `RING_DEPTH_MIN` / `RING_DEPTH_MAX`;
  - the buffer address width (RING_DEPTH_MAX), alongside the existing `BRAM_DEPTH`/`PE_DEPTH`.
- One sub-module, `ntt_obuf`: a simple dual-port RAM (1 write port, 1 read port, registered read) of 2^RING_DEPTH_MAX × DATA_W, inferable as BRAM.

## Test plan
- Reset asserted mid-DRAIN → all outputs 0 immediately. After release the block is in IDLE and `dout_valid` stays 0 until a new frame.
- q=8004097, N=256, words m carry value m+1, `dout_ready`=1 → k<128 yields 2k+1 and k≥128 yields 2(k−128)+2. Expect 256 consecutive words, `dout_last` on k=255, `done` one cycle later.
- Reduction (`OUT_REDUCE_EN` on): inputs 8004096, 8004097, 8004098 → 8004096, 0, 1. With the macro off → the same three values pass unchanged.
- Backpressure: `dout_ready` toggles 1,0,1,0 during drain → exactly 256 handshakes, no duplicates or omissions, `dout` stable while stalled.
- Overflow and abort:
  - a 257th `din_valid` during DRAIN → `err_ovf`=1 and the output stream stays correct;
  - `start` at m=100 → a fresh 256-word frame is captured correctly.
- ring_depth=10 (N=1024): odd words land at 512+(m>>1). `ring_depth`=7 at `start` → `err_cfg`=1 and the block stays in IDLE.

Source files
------------

// File: rtl/ntt_out_unpacker_pkg.sv
// Shared definitions for the NTT output unpacker: FSM encodings, ring-size
// limits and buffer geometry.
package ntt_out_unpacker_pkg;

    localparam int BRAM_DEPTH     = 1024;
    localparam int PE_DEPTH       = 8;
    localparam int RING_DEPTH_MIN = 8;
    localparam int RING_DEPTH_MAX = 10;
    // Output buffer address width: holds the largest ring.
    localparam int OBUF_AW        = RING_DEPTH_MAX;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } unpk_state_e;

endpackage

// File: rtl/ntt_obuf.sv
// Simple dual-port coefficient buffer: one write port, one registered read
// port. No reset on the array so it maps onto block RAM.
module ntt_obuf #(
    parameter int DATA_W = 32,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<AW)-1];

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ntt_out_unpacker.sv
// Captures the even/odd-interleaved NTT output stream into a local buffer at
// natural-order addresses, then replays it in order 0..N-1 over valid/ready.
// Optional feature: define OUT_REDUCE_EN to compile in the final conditional
// subtraction (x >= q ? x - q : x); otherwise words are stored unmodified.
module ntt_out_unpacker
    import ntt_out_unpacker_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        ring_depth,
    input  logic [DATA_W-1:0] q,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_last,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic              err_cfg
);

    localparam int AW = OBUF_AW;
    localparam int CW = AW + 1;

    unpk_state_e       state;
    logic [CW-1:0]     n_len, m_cnt, rd_ptr;
    logic              cfg_ok, cap_ok, accept, pop, rd_issue;
    logic [1:0]        held;
    logic [AW-1:0]     cap_addr;
    logic [DATA_W-1:0] reduced;

    logic              wr_en_q, wr_last_q;
    logic [AW-1:0]     wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              rd_vld_q, rd_last_q;
    logic [DATA_W-1:0] rd_data;
    logic              skid_vld, skid_last;
    logic [DATA_W-1:0] skid_data;

`ifdef OUT_REDUCE_EN
    logic [DATA_W-1:0] q_r;
    assign reduced = (din >= q_r) ? din - q_r : din;
`else
    logic unused_q;
    assign unused_q = ^q;
    assign reduced  = din;
`endif

    // Capture qualification, interleave address and drain read scheduling.
    always_comb begin
        cfg_ok   = (ring_depth >= 4'(RING_DEPTH_MIN)) && (ring_depth <= 4'(RING_DEPTH_MAX));
        cap_ok   = (state == ST_CAPTURE) && (m_cnt != n_len);
        accept   = din_valid && !start && cap_ok;
        // Even word m goes to m/2, odd word m to N/2 + m/2.
        cap_addr = m_cnt[AW:1] + (m_cnt[0] ? n_len[AW:1] : '0);
        pop      = dout_valid && dout_ready;
        // Entries held next cycle (output reg + skid + read in flight).
        held     = 2'(dout_valid) + 2'(skid_vld) + 2'(rd_vld_q) - 2'(pop);
        rd_issue = (state == ST_DRAIN) && (rd_ptr != n_len) && (held < 2'd2);
    end

    // Registered reduction stage feeding the buffer write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_q   <= 1'b0;
            wr_last_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= accept;
            wr_last_q <= (m_cnt == n_len - 1'b1);
            if (accept) begin
                wr_addr_q <= cap_addr;
                wr_data_q <= reduced;
            end
        end
    end

    // Control FSM, error flags, read pointer and 2-entry output skid buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            n_len      <= '0;
            m_cnt      <= '0;
            rd_ptr     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_ovf    <= 1'b0;
            err_cfg    <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            dout       <= '0;
            skid_vld   <= 1'b0;
            skid_last  <= 1'b0;
            skid_data  <= '0;
`ifdef OUT_REDUCE_EN
            q_r        <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (start) begin
                // Start (legal or not) abandons any frame in flight.
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
                skid_vld   <= 1'b0;
                rd_vld_q   <= 1'b0;
                if (cfg_ok) begin
                    state   <= ST_CAPTURE;
                    busy    <= 1'b1;
                    n_len   <= CW'(1) << ring_depth;
                    m_cnt   <= '0;
                    rd_ptr  <= '0;
                    err_ovf <= 1'b0;
                    err_cfg <= 1'b0;
`ifdef OUT_REDUCE_EN
                    q_r     <= q;
`endif
                end else begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    err_cfg <= 1'b1;
                end
            end else begin
                if (din_valid && !cap_ok) err_ovf <= 1'b1;
                if (accept) m_cnt <= m_cnt + 1'b1;

                rd_vld_q  <= rd_issue;
                rd_last_q <= (rd_ptr == n_len - 1'b1);
                if (rd_issue) rd_ptr <= rd_ptr + 1'b1;

                // Output register refills from skid first, then from RAM.
                if (!dout_valid || pop) begin
                    if (skid_vld) begin
                        dout       <= skid_data;
                        dout_last  <= skid_last;
                        dout_valid <= 1'b1;
                        skid_vld   <= rd_vld_q;
                        if (rd_vld_q) begin
                            skid_data <= rd_data;
                            skid_last <= rd_last_q;
                        end
                    end else if (rd_vld_q) begin
                        dout       <= rd_data;
                        dout_last  <= rd_last_q;
                        dout_valid <= 1'b1;
                    end else begin
                        dout_valid <= 1'b0;
                    end
                end else if (rd_vld_q) begin
                    skid_vld  <= 1'b1;
                    skid_data <= rd_data;
                    skid_last <= rd_last_q;
                end

                case (state)
                    ST_CAPTURE: if (wr_en_q && wr_last_q) state <= ST_DRAIN;
                    ST_DRAIN: if (pop && dout_last) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    ntt_obuf #(.DATA_W(DATA_W), .AW(AW)) u_obuf (
        .clk     (clk),
        .wr_en   (wr_en_q),
        .wr_addr (wr_addr_q),
        .wr_data (wr_data_q),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );

endmodule
